// File: rtl/sdfa_pkg.sv
// Shared constants for the SDFA result path: requester count, beat width,
// result-vector depth and the derived counter/pointer widths.
package sdfa_pkg;

    localparam int BLOCK_NUM         = 8;
    localparam int SDFA_NREQ         = BLOCK_NUM + 1;
    localparam int SDFA_DATA_W       = 8;
    localparam int SDFA_RESULT_DEPTH = 256;
    localparam int SDFA_CNT_W        = $clog2(SDFA_RESULT_DEPTH) + 1;
    localparam int SDFA_PTR_W        = $clog2(SDFA_NREQ);

    typedef logic [SDFA_PTR_W-1:0] sdfa_ptr_t;

    // Modular add for round-robin indices; base and off are both below n,
    // so a single subtraction is enough to wrap.
    function automatic int sdfa_wrap_add(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/sdfa_rr_pick.sv
// Rotating-priority picker: returns the first set bit of vec_i found when
// scanning upward from ptr_i and wrapping at NREQ-1 back to 0.
module sdfa_rr_pick
    import sdfa_pkg::*;
#(
    parameter int NREQ  = SDFA_NREQ,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  vec_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  onehot_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    logic [NREQ-1:0]  onehot_s;
    logic [PTR_W-1:0] idx_s;
    logic [PTR_W-1:0] cand_s;
    logic             seen_s;
    logic             hit_s;

    // Scan candidates in priority order; only the first set bit survives because
    // seen_s masks every later hit, so OR-accumulation yields a clean one-hot.
    always_comb begin
        onehot_s = {NREQ{1'b0}};
        idx_s    = {PTR_W{1'b0}};
        seen_s   = 1'b0;
        cand_s   = {PTR_W{1'b0}};
        hit_s    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s   = PTR_W'(sdfa_wrap_add(int'(ptr_i), k, NREQ));
            hit_s    = vec_i[cand_s] & ~seen_s;
            onehot_s = onehot_s | ({{(NREQ-1){1'b0}}, hit_s} << cand_s);
            idx_s    = idx_s | ({PTR_W{hit_s}} & cand_s);
            seen_s   = seen_s | vec_i[cand_s];
        end
    end

    assign onehot_o = onehot_s;
    assign idx_o    = idx_s;
    assign any_o    = seen_s;

endmodule

// File: rtl/sdfa_result_arbiter.sv
// Round-robin arbiter that serialises per-block SDFA results onto the single
// result bus feeding sdfa_master, with a one-beat output register, backpressure
// from the master and a saturating delivered-beat counter.
module sdfa_result_arbiter
    import sdfa_pkg::*;
#(
    parameter int NREQ         = SDFA_NREQ,
    parameter int DATA_W       = SDFA_DATA_W,
    parameter int RESULT_DEPTH = SDFA_RESULT_DEPTH,
    parameter int CNT_W        = $clog2(RESULT_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clear_i,
    input  logic [NREQ-1:0]        req_mask_i,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*DATA_W-1:0] req_data_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic                   res_stall_i,
    output logic [NREQ-1:0]        res_valid_o,
    output logic [DATA_W-1:0]      res_data_o,
    output logic [CNT_W-1:0]       result_count_o,
    output logic                   full_o
);

    localparam int PTR_W = $clog2(NREQ);

    logic [NREQ-1:0]   res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q,  res_data_d;
    logic [PTR_W-1:0]  ptr_q,       ptr_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic              full_q,      full_d;

    logic [NREQ-1:0]   elig_s;
    logic [NREQ-1:0]   pick_onehot_s;
    logic [PTR_W-1:0]  pick_idx_s;
    logic              pick_any_s;
    logic              stage_free_s;
    logic              grant_s;

    assign elig_s       = req_valid_i & req_mask_i;
    assign stage_free_s = ~(|res_valid_q) | ~res_stall_i;
    // rstn gates the grant so every output reads zero while reset is held.
    assign grant_s      = rstn & pick_any_s & stage_free_s & ~full_q & ~clear_i;

    sdfa_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .vec_i    (elig_s),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot_s),
        .idx_o    (pick_idx_s),
        .any_o    (pick_any_s)
    );

    assign req_ready_o = grant_s ? pick_onehot_s : {NREQ{1'b0}};

    // Next-state for output stage, pointer and counter; clear overrides a grant.
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        full_d      = full_q;
        if (clear_i) begin
            res_valid_d = {NREQ{1'b0}};
            ptr_d       = {PTR_W{1'b0}};
            count_d     = {CNT_W{1'b0}};
            full_d      = 1'b0;
        end else if (grant_s) begin
            res_valid_d = pick_onehot_s;
            res_data_d  = req_data_i[pick_idx_s*DATA_W +: DATA_W];
            ptr_d       = (pick_idx_s == PTR_W'(NREQ - 1)) ? {PTR_W{1'b0}}
                                                           : pick_idx_s + PTR_W'(1);
            count_d     = count_q + CNT_W'(1);
            full_d      = (count_q + CNT_W'(1)) == CNT_W'(RESULT_DEPTH);
        end else if (stage_free_s) begin
            res_valid_d = {NREQ{1'b0}};
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // State registers; reset drops any beat in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_valid_q <= {NREQ{1'b0}};
            res_data_q  <= {DATA_W{1'b0}};
            ptr_q       <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            full_q      <= 1'b0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
        end
    end

    assign res_valid_o    = res_valid_q;
    assign res_data_o     = res_data_q;
    assign result_count_o = count_q;
    assign full_o         = full_q;

endmodule
